// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a 4-way shared memory port; holds a grant for a whole transaction.
// Grant registered one cycle after request; release on done, requester abort or timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] slct,
  output logic       busy,
  output logic       mem_start,
  output logic       timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       slct_q, slct_d;
  logic             busy_q, busy_d;
  logic             mem_start_q, mem_start_d;
  logic             timeout_err_q, timeout_err_d;

  logic [1:0] win;
  logic       found;
  logic       to_hit;
  logic       abort;

  // Scan starting at the priority pointer; first set request wins.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        win   = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign abort  = !req[slct_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    slct_d        = slct_q;
    busy_d        = busy_q;
    mem_start_d   = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d     = 4'b0001 << win;
          slct_d      = win;
          busy_d      = 1'b1;
          mem_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (done || abort || to_hit) begin
          grant_d       = 4'b0000;
          busy_d        = 1'b0;
          ptr_d         = slct_q + 2'd1;
          state_d       = IDLE;
          // done and abort both outrank the timeout, so no error flag then.
          timeout_err_d = !done && !abort;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      slct_q        <= '0;
      busy_q        <= 1'b0;
      mem_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      slct_q        <= slct_d;
      busy_q        <= busy_d;
      mem_start_q   <= mem_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign slct        = slct_q;
  assign busy        = busy_q;
  assign mem_start   = mem_start_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: expected grants queued at request time, checked on mem_start.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] slct;
  logic       busy;
  logic       mem_start;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  mem_port_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .slct(slct), .busy(busy),
    .mem_start(mem_start), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and invariant monitor on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ((busy !== |grant) || ((grant & (grant - 4'd1)) !== 4'd0) || (busy && grant[slct] !== 1'b1)) begin
        fails++;
        $display("FAIL invariant: grant=%b slct=%0d busy=%b", grant, slct, busy);
      end
      if (mem_start === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: grant=%b with nothing expected", grant);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (grant !== e) begin
            fails++;
            $display("FAIL sb_grant: got %b expected %b", grant, e);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    #3;
    tests++;
    if ({grant, slct, busy, mem_start, timeout_err} !== 9'd0) begin
      fails++;
      $display("FAIL reset_vals: got %b expected 0", {grant, slct, busy, mem_start, timeout_err});
    end
    tick; tick;
    rst = 1'b0;
    tick;
    tests++;
    if ({grant, busy} !== 5'd0) begin
      fails++;
      $display("FAIL reset_idle: got %b expected 0", {grant, busy});
    end
  endtask

  task automatic test_single;
    req = 4'b0100; exp_q.push_back(4'b0100);
    tick;
    tests++;
    if (grant !== 4'b0100 || slct !== 2'd2 || busy !== 1'b1 || mem_start !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: grant=%b slct=%0d busy=%b ms=%b expected 0100 2 1 1", grant, slct, busy, mem_start);
    end
    tick;
    tests++;
    if (mem_start !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_hold: ms=%b busy=%b expected 0 1", mem_start, busy);
    end
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    tests++;
    if (grant !== 4'b0000 || busy !== 1'b0 || slct !== 2'd2) begin
      fails++;
      $display("FAIL single_release: grant=%b busy=%b slct=%0d expected 0000 0 2", grant, busy, slct);
    end
    // ptr now 3: port 3 must beat port 2.
    req = 4'b1100; exp_q.push_back(4'b1000);
    tick;
    tests++;
    if (grant !== 4'b1000) begin
      fails++;
      $display("FAIL single_ptr3: got %b expected 1000", grant);
    end
    done = 1'b1; tick; done = 1'b0;
    req = 4'b0000; tick;
  endtask

  task automatic test_round_robin;
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(seq[i]);
      tick;
      tests++;
      if (grant !== seq[i] || slct !== 2'(i % 4) || mem_start !== 1'b1) begin
        fails++;
        $display("FAIL rr_grant%0d: grant=%b slct=%0d ms=%b expected %b %0d 1", i, grant, slct, mem_start, seq[i], i % 4);
      end
      tick;
      done = 1'b1;
      tick;
      done = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL rr_idle%0d: busy=%b expected 0", i, busy);
      end
    end
    req = 4'b0000; tick;
  endtask

  task automatic test_priority;
    req = 4'b0010; exp_q.push_back(4'b0010);
    tick; done = 1'b1; tick; done = 1'b0;
    req = 4'b0011; exp_q.push_back(4'b0001);
    tick;
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL prio_ptr2: got %b expected 0001", grant);
    end
    done = 1'b1; tick; done = 1'b0;
    req = 4'b0110; exp_q.push_back(4'b0010);
    tick;
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL prio_ptr1: got %b expected 0010", grant);
    end
    done = 1'b1; tick; done = 1'b0;
    req = 4'b0000; tick;
  endtask

  task automatic test_timeout;
    int n;
    req = 4'b1000; exp_q.push_back(4'b1000);
    tick;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tests++;
      if (timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL to_early: timeout_err=1 at busy cycle %0d", n);
      end
      n++;
      tick;
    end
    req = 4'b0000;
    tests++;
    if (n != 15 || timeout_err !== 1'b1 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL to_release: cycles=%0d terr=%b grant=%b expected 15 1 0000", n, timeout_err, grant);
    end
    tick;
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL to_pulse: terr=%b expected 0", timeout_err);
    end
    // ptr wrapped to 0 after port 3.
    req = 4'b1001; exp_q.push_back(4'b0001);
    tick;
    tests++;
    if (grant !== 4'b0001) begin
      fails++;
      $display("FAIL to_ptr0: got %b expected 0001", grant);
    end
    done = 1'b1; tick; done = 1'b0;
    req = 4'b0000; tick;
  endtask

  task automatic test_collision_abort;
    req = 4'b0100; exp_q.push_back(4'b0100);
    tick;
    for (int i = 0; i < 14; i++) tick;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL coll_busy: busy=%b expected 1", busy);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    tests++;
    if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL coll_release: grant=%b terr=%b expected 0000 0", grant, timeout_err);
    end
    req = 4'b0000; tick;
    req = 4'b0100; exp_q.push_back(4'b0100);
    tick; tick; tick;
    req = 4'b0000;
    tick;
    tests++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL abort_release: grant=%b busy=%b terr=%b expected 0000 0 0", grant, busy, timeout_err);
    end
    tick;
    tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_after: terr=%b busy=%b expected 0 0", timeout_err, busy);
    end
  endtask

  task automatic test_midreset;
    req = 4'b0010; exp_q.push_back(4'b0010);
    tick;
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL mrst_grant: got %b expected 0010", grant);
    end
    tick;
    #3 rst = 1'b1;
    #1;
    tests++;
    if (grant !== 4'b0000 || busy !== 1'b0 || slct !== 2'd0 || timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL mrst_async: grant=%b busy=%b slct=%0d terr=%b expected 0000 0 0 0", grant, busy, slct, timeout_err);
    end
    #2 rst = 1'b0;
    // ptr back at 0: port 1 beats port 2.
    req = 4'b0110; exp_q.push_back(4'b0010);
    tick;
    tests++;
    if (grant !== 4'b0010 || slct !== 2'd1) begin
      fails++;
      $display("FAIL mrst_regrant: grant=%b slct=%0d expected 0010 1", grant, slct);
    end
    done = 1'b1; tick; done = 1'b0;
    req = 4'b0000; tick;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d grants expected but never seen", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_collision_abort();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
